masked_and_hpc2_stream: RTL and testbench
=========================================

MASKED_AND_HPC2_STREAM -- requirements
Module: masked_and_hpc2_stream

Interface
REQ-001 Parameter security_order, default 1: masking order; share count d = security_order+1.
REQ-002 Parameter lanes, default 4: number of independent masked AND lanes evaluated in parallel.
REQ-003 Local constant rnd = security_order*(security_order+1)/2 random bits per lane; total random width R = lanes*rnd.
REQ-004 clk  input  1  clock; all registers update on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  a and b carry a new operand pair.
REQ-007 in_ready  output  1  the block accepts the operand pair this cycle.
REQ-008 a  input  lanes*d  shares of operand a; lane k, share i at bit k*d+i.
REQ-009 b  input  lanes*d  shares of operand b; same layout as a.
REQ-010 r  input  R  fresh randomness; lane k, pair index p at bit k*rnd+p.
REQ-011 r_valid  input  1  r holds unused fresh randomness.
REQ-012 r_ready  output  1  r is consumed this cycle.
REQ-013 c  output  lanes*d  output shares, same layout as a.
REQ-014 out_valid  output  1  c holds a result.
REQ-015 out_ready  input  1  the downstream consumer takes c this cycle.

Function
REQ-016 Per lane: XOR of the c shares SHALL equal (XOR of a shares) AND (XOR of b shares) of the accepted pair.
REQ-017 Pair index p maps to share pairs i<j in row-major order (0,1),(0,2)..(0,d-1),(1,2)..; r_ji = r_ij.
REQ-018 Stage 1 registers a_i, b_i, (b_j XOR r_ij) and (NOT a_i AND r_ij) for j != i; each product and sum sits in its own register with no glitch path merging shares.
REQ-019 Stage 2: c_i = reg(a1_i AND b1_i) XOR sum over j != i of [reg(NOT-a term) XOR reg(a1_i AND stage-1 (b_j XOR r_ij))], where a1 and b1 are the stage-1 copies.
REQ-020 Latency is exactly 2 cycles from accept to out_valid when no stall occurs.
REQ-021 Pipeline enable en = NOT out_valid OR out_ready; both stages and their valid bits advance only when en = 1.
REQ-022 in_ready = en AND r_valid; accept = in_valid AND in_ready.
REQ-023 r_ready = accept; each random word is used for exactly one operand pair and is never reused.
REQ-024 A stage whose valid bit is 0 advances and captures a bubble; bubbles do not raise out_valid.
REQ-025 When en = 0, every share register holds its value; c and out_valid are stable until out_ready = 1.
REQ-026 Throughput: one result per cycle while in_valid, r_valid and out_ready stay high.
REQ-027 in_valid = 1 with r_valid = 0: no accept, r_ready = 0, no data registers change.

Reset
REQ-028 rst = 1 clears both stage valid bits and out_valid to 0 immediately, independent of clk.
REQ-029 Reset clears all share registers to 0, so c = 0 during and after reset.
REQ-030 During rst, in_ready = 0 and r_ready = 0; operands in flight are discarded with no output.
REQ-031 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-032 d=2, lanes=1: a shares (1,0), b shares (1,1), r=1, out_ready=1 -> out_valid=1 two cycles later, c0 XOR c1 = 0; a=(1,0), b=(0,1) -> XOR = 1.
REQ-033 Random operands, security_order=2, lanes=4, 1000 pairs, random out_ready and r_valid -> every lane matches REQ-016, results in order, none lost or duplicated.
REQ-034 Hold out_ready=0 with the pipeline full -> in_ready=0, c unchanged for 5 cycles; set out_ready=1 -> the 2 queued results drain on consecutive cycles.
REQ-035 r_valid=0, in_valid=1 for 3 cycles -> r_ready=0 and no accept; r_valid=1 -> accept on that cycle and out_valid 2 cycles later.
REQ-036 Assert rst asynchronously with 2 results in flight -> out_valid=0 and c=0 without waiting for a clock edge; after release, no stale result appears.
REQ-037 Sweep security_order 1..3 with all-zero r -> function still correct; the same vectors with random r give the same unmasked result while the individual shares differ.

Source files
------------

// File: rtl/masked_and_hpc2_stream.sv
// Streaming HPC2 masked AND: `lanes` independent d-share AND gadgets in a two-stage
// pipeline with valid/ready handshakes on operands, randomness and results.
module masked_and_hpc2_stream #(
  parameter int unsigned security_order = 1,
  parameter int unsigned lanes          = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [lanes*(security_order+1)-1:0]               a,
  input  logic [lanes*(security_order+1)-1:0]               b,
  input  logic [lanes*security_order*(security_order+1)/2-1:0] r,
  input  logic                                              r_valid,
  output logic                                              r_ready,
  output logic [lanes*(security_order+1)-1:0]               c,
  output logic                                              out_valid,
  input  logic                                              out_ready
);

  localparam int unsigned D   = security_order + 1;
  localparam int unsigned RND = security_order * (security_order + 1) / 2;

  typedef logic [lanes-1:0][D-1:0]        vec_t;
  typedef logic [lanes-1:0][D-1:0][D-1:0] mat_t;

  // Row-major index of unordered share pair {i,j}, i != j.
  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    int unsigned lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * D - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic en_c;
  logic accept_c;
  logic rb;
  logic valid1_q, valid2_q;
  vec_t a1_q, a1_d;
  // Diagonal of s1 holds the b_i copy; off-diagonal holds b_j ^ r_ij.
  mat_t s1_q, s1_d;
  mat_t na1_q, na1_d;
  // Diagonal of v holds a1_i & b1_i; diagonal of u is always zero.
  mat_t u_q, u_d;
  mat_t v_q, v_d;

  assign en_c      = ~valid2_q | out_ready;
  assign in_ready  = en_c & r_valid & ~rst;
  assign accept_c  = in_valid & in_ready;
  assign r_ready   = accept_c;
  assign out_valid = valid2_q;

  // Stage 1 next values: share copies, refreshed b and masked NOT-a terms.
  always_comb begin
    rb    = 1'b0;
    a1_d  = '0;
    s1_d  = '0;
    na1_d = '0;
    for (int unsigned k = 0; k < lanes; k++) begin
      for (int unsigned i = 0; i < D; i++) begin
        a1_d[k][i] = a[k*D+i];
        for (int unsigned j = 0; j < D; j++) begin
          if (j == i) begin
            s1_d[k][i][j] = b[k*D+i];
          end else begin
            rb                 = r[k*RND+pair_idx(i, j)];
            s1_d[k][i][j]  = b[k*D+j] ^ rb;
            na1_d[k][i][j] = ~a[k*D+i] & rb;
          end
        end
      end
    end
  end

  // Stage 2 next values: every partial product kept in its own register.
  always_comb begin
    u_d = na1_q;
    v_d = '0;
    for (int unsigned k = 0; k < lanes; k++) begin
      for (int unsigned i = 0; i < D; i++) begin
        for (int unsigned j = 0; j < D; j++) begin
          v_d[k][i][j] = a1_q[k][i] & s1_q[k][i][j];
        end
      end
    end
  end

  // Output shares: XOR compression of registered stage-2 terms only.
  always_comb begin
    c = '0;
    for (int unsigned k = 0; k < lanes; k++) begin
      for (int unsigned i = 0; i < D; i++) begin
        for (int unsigned j = 0; j < D; j++) begin
          c[k*D+i] = c[k*D+i] ^ u_q[k][i][j] ^ v_q[k][i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      a1_q     <= '0;
      s1_q     <= '0;
      na1_q    <= '0;
      u_q      <= '0;
      v_q      <= '0;
    end else begin
      if (en_c) begin
        valid1_q <= accept_c;
        valid2_q <= valid1_q;
      end
      if (accept_c) begin
        a1_q  <= a1_d;
        s1_q  <= s1_d;
        na1_q <= na1_d;
      end
      // Bubbles leave stage-2 data untouched; only the valid bit drains.
      if (en_c && valid1_q) begin
        u_q <= u_d;
        v_q <= v_d;
      end
    end
  end

endmodule

// File: tb/tb_masked_and_hpc2_stream.sv
// Self-checking bench for masked_and_hpc2_stream: three instances (orders 1..3)
// share clock, reset and handshake controls; results checked on unmasked values.
module tb_masked_and_hpc2_stream;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, r_valid, out_ready;

  // Main instance: order 2, 4 lanes (d=3, 3 random bits per lane).
  logic [11:0] a_m, b_m, c_m, r_m;
  logic        in_ready_m, r_ready_m, out_valid_m;
  // Order 1, 1 lane (d=2, 1 random bit).
  logic [1:0]  a_1, b_1, c_1;
  logic [0:0]  r_1;
  logic        in_ready_1, r_ready_1, out_valid_1;
  // Order 3, 2 lanes (d=4, 6 random bits per lane).
  logic [7:0]  a_3, b_3, c_3;
  logic [11:0] r_3;
  logic        in_ready_3, r_ready_3, out_valid_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  masked_and_hpc2_stream #(.security_order(2), .lanes(4)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
    .a(a_m), .b(b_m), .r(r_m), .r_valid(r_valid), .r_ready(r_ready_m),
    .c(c_m), .out_valid(out_valid_m), .out_ready(out_ready));

  masked_and_hpc2_stream #(.security_order(1), .lanes(1)) dut_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .a(a_1), .b(b_1), .r(r_1), .r_valid(r_valid), .r_ready(r_ready_1),
    .c(c_1), .out_valid(out_valid_1), .out_ready(out_ready));

  masked_and_hpc2_stream #(.security_order(3), .lanes(2)) dut_3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_3),
    .a(a_3), .b(b_3), .r(r_3), .r_valid(r_valid), .r_ready(r_ready_3),
    .c(c_3), .out_valid(out_valid_3), .out_ready(out_ready));

  // Reference: per-lane unmasked value is the parity of its shares.
  function automatic logic [7:0] lanes_par(input logic [63:0] v, input int d, input int l);
    logic [7:0] res;
    res = '0;
    for (int k = 0; k < l; k++)
      for (int i = 0; i < d; i++) res[k] = res[k] ^ v[k*d+i];
    return res;
  endfunction

  function automatic logic [7:0] lanes_and(input logic [63:0] av, input logic [63:0] bv,
                                           input int d, input int l);
    return lanes_par(av, d, l) & lanes_par(bv, d, l);
  endfunction

  // One isolated transaction on all instances; returns at the negedge two edges after accept.
  task automatic run_one();
    @(posedge clk); #1;
    in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; r_valid = 1'b1; out_ready = 1'b1;
    a_m = 12'h5a3; b_m = 12'h3c7; r_m = 12'h0f1;
    a_1 = '0; b_1 = '0; r_1 = '0; a_3 = '0; b_3 = '0; r_3 = '0;
    #3;
    checks++; if (in_ready_m !== 1'b0 || r_ready_m !== 1'b0) begin
      errors++; $display("FAIL reset_ready got in_ready=%b r_ready=%b exp 0 0", in_ready_m, r_ready_m); end
    @(posedge clk); #1;
    checks++; if (out_valid_m !== 1'b0 || c_m !== 12'h0) begin
      errors++; $display("FAIL reset_out got valid=%b c=%h exp 0 000", out_valid_m, c_m); end
    checks++; if (c_1 !== 2'b0 || c_3 !== 8'h0 || out_valid_1 !== 1'b0 || out_valid_3 !== 1'b0) begin
      errors++; $display("FAIL reset_aux got c1=%h c3=%h exp 0 0", c_1, c_3); end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (in_ready_m !== 1'b1) begin
      errors++; $display("FAIL first_accept_ready got %b exp 1", in_ready_m); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid_m !== 1'b1 || lanes_par(64'(c_m), 3, 4) !== lanes_and(64'(a_m), 64'(b_m), 3, 4)) begin
      errors++; $display("FAIL first_accept_result got valid=%b val=%h exp 1 %h", out_valid_m,
                         lanes_par(64'(c_m), 3, 4), lanes_and(64'(a_m), 64'(b_m), 3, 4)); end
  endtask

  task automatic test_basic();
    a_1 = 2'b01; b_1 = 2'b11; r_1 = 1'b1;
    run_one();
    checks++; if (out_valid_1 !== 1'b1 || (c_1[0] ^ c_1[1]) !== 1'b0) begin
      errors++; $display("FAIL basic_and0 got valid=%b xor=%b exp 1 0", out_valid_1, c_1[0] ^ c_1[1]); end
    a_1 = 2'b01; b_1 = 2'b10; r_1 = 1'b1;
    run_one();
    checks++; if (out_valid_1 !== 1'b1 || (c_1[0] ^ c_1[1]) !== 1'b1) begin
      errors++; $display("FAIL basic_and1 got valid=%b xor=%b exp 1 1", out_valid_1, c_1[0] ^ c_1[1]); end
  endtask

  task automatic test_rvalid_gate();
    logic [7:0] ea;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; r_valid = 1'b0;
    a_m = 12'($urandom); b_m = 12'($urandom); r_m = 12'($urandom);
    ea = lanes_and(64'(a_m), 64'(b_m), 3, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (r_ready_m !== 1'b0 || in_ready_m !== 1'b0 || out_valid_m !== 1'b0) begin
        errors++; $display("FAIL rvalid_low cyc%0d got r_ready=%b in_ready=%b out_valid=%b exp 0 0 0",
                           i, r_ready_m, in_ready_m, out_valid_m); end
    end
    @(posedge clk); #1; r_valid = 1'b1;
    @(negedge clk);
    checks++; if (r_ready_m !== 1'b1) begin
      errors++; $display("FAIL rvalid_accept got r_ready=%b exp 1", r_ready_m); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b0) begin
      errors++; $display("FAIL rvalid_latency1 got out_valid=%b exp 0", out_valid_m); end
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b1 || lanes_par(64'(c_m), 3, 4) !== ea) begin
      errors++; $display("FAIL rvalid_result got valid=%b val=%h exp 1 %h", out_valid_m,
                         lanes_par(64'(c_m), 3, 4), ea); end
  endtask

  task automatic test_stall();
    logic [7:0]  ea, eb;
    logic [11:0] held;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; r_valid = 1'b1;
    a_m = 12'($urandom); b_m = 12'($urandom); r_m = 12'($urandom);
    ea = lanes_and(64'(a_m), 64'(b_m), 3, 4);
    @(posedge clk); #1;
    a_m = 12'($urandom); b_m = 12'($urandom); r_m = 12'($urandom);
    eb = lanes_and(64'(a_m), 64'(b_m), 3, 4);
    @(posedge clk); #1;
    a_m = 12'($urandom); b_m = 12'($urandom); r_m = 12'($urandom);
    @(negedge clk);
    held = c_m;
    checks++; if (lanes_par(64'(held), 3, 4) !== ea) begin
      errors++; $display("FAIL stall_first got %h exp %h", lanes_par(64'(held), 3, 4), ea); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid_m !== 1'b1 || in_ready_m !== 1'b0 || r_ready_m !== 1'b0 || c_m !== held) begin
        errors++; $display("FAIL stall_hold cyc%0d got valid=%b in_ready=%b c=%h exp 1 0 %h",
                           i, out_valid_m, in_ready_m, c_m, held); end
      @(negedge clk);
    end
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b1 || lanes_par(64'(c_m), 3, 4) !== ea) begin
      errors++; $display("FAIL drain_a got valid=%b val=%h exp 1 %h", out_valid_m, lanes_par(64'(c_m), 3, 4), ea); end
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b1 || lanes_par(64'(c_m), 3, 4) !== eb) begin
      errors++; $display("FAIL drain_b got valid=%b val=%h exp 1 %h", out_valid_m, lanes_par(64'(c_m), 3, 4), eb); end
    @(negedge clk);
    checks++; if (out_valid_m !== 1'b0) begin
      errors++; $display("FAIL drain_empty got out_valid=%b exp 0", out_valid_m); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; r_valid = 1'b1;
    a_m = 12'($urandom); b_m = 12'($urandom); r_m = 12'($urandom);
    @(posedge clk); #1;
    a_m = 12'($urandom); b_m = 12'($urandom); r_m = 12'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid_m !== 1'b1) begin
      errors++; $display("FAIL areset_inflight got out_valid=%b exp 1", out_valid_m); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid_m !== 1'b0 || c_m !== 12'h0 || in_ready_m !== 1'b0 || r_ready_m !== 1'b0) begin
      errors++; $display("FAIL areset_immediate got valid=%b c=%h in_ready=%b exp 0 000 0",
                         out_valid_m, c_m, in_ready_m); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (out_valid_m !== 1'b0 || c_m !== 12'h0) begin
        errors++; $display("FAIL areset_stale cyc%0d got valid=%b c=%h exp 0 000", i, out_valid_m, c_m); end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] c0_m;
    logic [1:0]  c0_1;
    logic [7:0]  c0_3;
    int diff_m, diff_1, diff_3;
    diff_m = 0; diff_1 = 0; diff_3 = 0;
    for (int v = 0; v < 6; v++) begin
      a_m = 12'($urandom); b_m = 12'($urandom);
      a_1 = 2'($urandom);  b_1 = 2'($urandom);
      a_3 = 8'($urandom);  b_3 = 8'($urandom);
      for (int pass = 0; pass < 2; pass++) begin
        r_m = (pass == 0) ? 12'h0 : 12'($urandom);
        r_1 = (pass == 0) ? 1'b0 : 1'b1;
        r_3 = (pass == 0) ? 12'h0 : 12'($urandom);
        run_one();
        checks++; if (out_valid_1 !== 1'b1 || lanes_par(64'(c_1), 2, 1) !== lanes_and(64'(a_1), 64'(b_1), 2, 1)) begin
          errors++; $display("FAIL sweep_o1 v%0d p%0d got %h exp %h", v, pass,
                             lanes_par(64'(c_1), 2, 1), lanes_and(64'(a_1), 64'(b_1), 2, 1)); end
        checks++; if (out_valid_m !== 1'b1 || lanes_par(64'(c_m), 3, 4) !== lanes_and(64'(a_m), 64'(b_m), 3, 4)) begin
          errors++; $display("FAIL sweep_o2 v%0d p%0d got %h exp %h", v, pass,
                             lanes_par(64'(c_m), 3, 4), lanes_and(64'(a_m), 64'(b_m), 3, 4)); end
        checks++; if (out_valid_3 !== 1'b1 || lanes_par(64'(c_3), 4, 2) !== lanes_and(64'(a_3), 64'(b_3), 4, 2)) begin
          errors++; $display("FAIL sweep_o3 v%0d p%0d got %h exp %h", v, pass,
                             lanes_par(64'(c_3), 4, 2), lanes_and(64'(a_3), 64'(b_3), 4, 2)); end
        if (pass == 0) begin
          c0_m = c_m; c0_1 = c_1; c0_3 = c_3;
        end else begin
          if (c_m != c0_m) diff_m++;
          if (c_1 != c0_1) diff_1++;
          if (c_3 != c0_3) diff_3++;
        end
      end
    end
    checks++; if (diff_1 == 0) begin errors++; $display("FAIL sweep_shares_o1 got differing=%0d exp >0", diff_1); end
    checks++; if (diff_m == 0) begin errors++; $display("FAIL sweep_shares_o2 got differing=%0d exp >0", diff_m); end
    checks++; if (diff_3 == 0) begin errors++; $display("FAIL sweep_shares_o3 got differing=%0d exp >0", diff_3); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] e;
    bit mv1, mv2, hold, exp_acc;
    int acc, cyc;
    mv1 = 1'b0; mv2 = 1'b0; hold = 1'b0; acc = 0; cyc = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    while ((acc < 1000 || q.size() != 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) begin
        a_m = 12'($urandom); b_m = 12'($urandom);
        in_valid = (acc < 1000) && ($urandom_range(3) != 0);
      end
      r_m = 12'($urandom);
      r_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      exp_acc = in_valid && r_valid && (!mv2 || out_ready);
      checks++; if (in_ready_m !== (r_valid && (!mv2 || out_ready)) || r_ready_m !== exp_acc || out_valid_m !== mv2) begin
        errors++; $display("FAIL rand_handshake cyc%0d got in_ready=%b r_ready=%b out_valid=%b exp %b %b %b",
                           cyc, in_ready_m, r_ready_m, out_valid_m, r_valid && (!mv2 || out_ready), exp_acc, mv2); end
      if (mv2 && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra cyc%0d got result with empty queue exp none", cyc);
        end else begin
          e = q.pop_front();
          if (lanes_par(64'(c_m), 3, 4) !== e) begin
            errors++; $display("FAIL rand_data cyc%0d got %h exp %h", cyc, lanes_par(64'(c_m), 3, 4), e); end
        end
      end
      if (exp_acc) begin
        q.push_back(lanes_and(64'(a_m), 64'(b_m), 3, 4));
        acc++;
      end
      hold = in_valid && !exp_acc;
      if (!mv2 || out_ready) begin
        mv2 = mv1;
        mv1 = exp_acc;
      end
    end
    checks++; if (acc != 1000 || q.size() != 0) begin
      errors++; $display("FAIL rand_complete got accepted=%0d pending=%0d exp 1000 0", acc, q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rvalid_gate();
    test_stall();
    test_async_reset();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
